// File: rtl/uart_echo_pkg.sv
// ---------------------------------------------------------------------------
// uart_echo_pkg
// Shared types and helpers for the UART echo / seven-segment display block.
//   rx_state_t / tx_state_t : serial FSM states (IDLE, START, DATA, STOP)
//   DATA_BITS               : payload bits per 8N1 frame
//   hex_to_seg()            : 4-bit value -> active-low {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
package uart_echo_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Active-low segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/echo_fifo.sv
// ---------------------------------------------------------------------------
// echo_fifo
// Synchronous FIFO buffering received bytes until the transmitter takes them.
// No write-through: a byte pushed into an empty FIFO is visible on dout the
// cycle after the push.
//   clk, rst : clock and synchronous active-high reset
//   push,din : write request and data (dropped when full unless popping)
//   pop,dout : read request (ignored when empty) and head-of-queue data
//   full     : DEPTH entries held
//   empty    : no entries held
// ---------------------------------------------------------------------------
module echo_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == (AW+1)'(0));
  assign dout  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= (AW+1)'(0);
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/uart_echo_display.sv
// ---------------------------------------------------------------------------
// uart_echo_display
// Receives 8N1 bytes, buffers them in echo_fifo and re-transmits them, while
// showing the most recent NUM_DIGITS/2 bytes in hex on a multiplexed
// active-low seven-segment display.
//   clk, rst : clock and synchronous active-high reset
//   uart_rx  : asynchronous serial input (idle high)
//   uart_tx  : registered serial output (idle high)
//   tx_en    : allows the transmitter to start a new byte (checked when idle)
//   seg      : {dp,g,f,e,d,c,b,a}, active-low, dp always off
//   an       : one-cold digit enables
//   led      : toggles on every good received byte
//   err      : sticky framing error / FIFO overflow, cleared only by rst
// ---------------------------------------------------------------------------
module uart_echo_display
  import uart_echo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_CNT  = 100000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  uart_rx,
  output logic                  uart_tx,
  input  logic                  tx_en,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  led,
  output logic                  err
);

  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam int RW     = $clog2(REFRESH_CNT);
  localparam int DW     = $clog2(NUM_DIGITS);
  localparam int DISP_W = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] BIT_LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT     = CW'(CLKS_PER_BIT / 2);
  // The IDLE cycle that follows STOP supplies the last stop-bit cycle, so
  // back-to-back frames get exactly CLKS_PER_BIT stop cycles.
  localparam logic [CW-1:0] STOP_LAST    = CW'(CLKS_PER_BIT - 2);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CNT - 1);
  localparam logic [DW-1:0] DIGIT_LAST   = DW'(NUM_DIGITS - 1);

  // RX side
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_t            rx_state_q;
  logic [CW-1:0]        rx_cnt_q;
  logic [2:0]           rx_bit_q;
  logic [DATA_BITS-1:0] rx_shift_q;
  logic                 good_byte_s, frame_err_s;
  logic                 push_q, led_q, err_q;
  logic [DISP_W-1:0]    disp_q, disp_shift_s;

  // FIFO / TX side
  logic [DATA_BITS-1:0] fifo_dout_s;
  logic                 fifo_full_s, fifo_empty_s;
  logic                 tx_pop_s, overflow_s;
  tx_state_t            tx_state_q;
  logic [CW-1:0]        tx_cnt_q;
  logic [2:0]           tx_bit_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic                 uart_tx_q;

  // Display side
  logic [RW-1:0]         refresh_cnt_q;
  logic [DW-1:0]         digit_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic [7:0]            seg_q;
  logic [3:0]            nibble_s;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Stop-bit verdict is taken in the last counted cycle of RX_STOP.
  assign good_byte_s = (rx_state_q == RX_STOP) && (rx_cnt_q == BIT_LAST) && rx_sync_q;
  assign frame_err_s = (rx_state_q == RX_STOP) && (rx_cnt_q == BIT_LAST) && !rx_sync_q;

  // Receive FSM: start-bit qualification, LSB-first shift, stop-bit sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= CW'(0);
      rx_bit_q   <= 3'd0;
      rx_shift_q <= '0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          rx_cnt_q <= CW'(0);
          rx_bit_q <= 3'd0;
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_q == HALF_BIT) begin
            rx_cnt_q   <= CW'(0);
            // Line back high at mid start bit: treat as a glitch.
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= CW'(0);
            rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'(DATA_BITS - 1)) begin
              rx_state_q <= RX_STOP;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= CW'(0);
            rx_state_q <= RX_IDLE;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        default: begin
          rx_state_q <= RX_IDLE;
          rx_cnt_q   <= CW'(0);
        end
      endcase
    end
  end

  // New byte enters at the LSBs; the oldest byte falls off the top.
  always_comb begin
    disp_shift_s                  = disp_q << DATA_BITS;
    disp_shift_s[DATA_BITS-1:0]   = rx_shift_q;
  end

  // Good-byte side effects: FIFO push request, activity LED, display history.
  always_ff @(posedge clk) begin
    if (rst) begin
      push_q <= 1'b0;
      led_q  <= 1'b0;
      disp_q <= '0;
    end else begin
      push_q <= good_byte_s;
      if (good_byte_s) begin
        led_q  <= ~led_q;
        disp_q <= disp_shift_s;
      end
    end
  end

  // Sticky error: framing error or a push that the full FIFO cannot take.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | frame_err_s | overflow_s;
    end
  end

  assign tx_pop_s   = (tx_state_q == TX_IDLE) && tx_en && !fifo_empty_s;
  assign overflow_s = push_q && fifo_full_s && !tx_pop_s;

  echo_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .din   (rx_shift_q),
    .pop   (tx_pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Transmit FSM; uart_tx_q reflects the state one cycle later, so the start
  // bit appears the cycle after the pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= CW'(0);
      tx_bit_q   <= 3'd0;
      tx_shift_q <= '0;
      uart_tx_q  <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          uart_tx_q <= 1'b1;
          tx_cnt_q  <= CW'(0);
          tx_bit_q  <= 3'd0;
          if (tx_pop_s) begin
            tx_shift_q <= fifo_dout_s;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          uart_tx_q <= 1'b0;
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= CW'(0);
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        TX_DATA: begin
          uart_tx_q <= tx_shift_q[0];
          if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_q   <= CW'(0);
            tx_shift_q <= tx_shift_q >> 1;
            tx_bit_q   <= tx_bit_q + 3'd1;
            if (tx_bit_q == 3'(DATA_BITS - 1)) begin
              tx_state_q <= TX_STOP;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        TX_STOP: begin
          uart_tx_q <= 1'b1;
          if (tx_cnt_q == STOP_LAST) begin
            tx_cnt_q   <= CW'(0);
            tx_state_q <= TX_IDLE;
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        default: begin
          uart_tx_q  <= 1'b1;
          tx_state_q <= TX_IDLE;
          tx_cnt_q   <= CW'(0);
        end
      endcase
    end
  end

  assign nibble_s = disp_q[{digit_q, 2'b00} +: 4];

  // Digit multiplexing; an and seg are both registered from digit_q so they
  // always change together.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_q <= RW'(0);
      digit_q       <= DW'(0);
      an_q          <= ~NUM_DIGITS'(1);
      seg_q         <= 8'hC0;
    end else begin
      if (refresh_cnt_q == REFRESH_LAST) begin
        refresh_cnt_q <= RW'(0);
        digit_q       <= (digit_q == DIGIT_LAST) ? DW'(0) : digit_q + DW'(1);
      end else begin
        refresh_cnt_q <= refresh_cnt_q + RW'(1);
      end
      an_q  <= ~(NUM_DIGITS'(1) << digit_q);
      seg_q <= {1'b1, hex_to_seg(nibble_s)};
    end
  end

  assign uart_tx = uart_tx_q;
  assign seg     = seg_q;
  assign an      = an_q;
  assign led     = led_q;
  assign err     = err_q;

endmodule

// File: tb/tb_uart_echo_display.sv
module tb_uart_echo_display;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int ND    = 4;
  localparam int RCNT  = 8;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          uart_rx = 1'b1;
  logic          tx_en   = 1'b0;
  logic          uart_tx;
  logic [7:0]    seg;
  logic [ND-1:0] an;
  logic          led;
  logic          err;

  uart_echo_display #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .NUM_DIGITS   (ND),
    .REFRESH_CNT  (RCNT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .tx_en   (tx_en),
    .seg     (seg),
    .an      (an),
    .led     (led),
    .err     (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Cycle bookkeeping
  int   cyc         = 0;
  int   n_since_rst = 0;
  logic rst_seen    = 1'b0;
  logic armed       = 1'b0;

  // Behavioural model state
  logic [15:0] disp_m     = 16'h0000;
  logic        led_m      = 1'b0;
  logic        err_m      = 1'b0;
  logic [7:0]  exp_q[$];
  int          starts[$];
  int          mask_until = 0;

  // Hex digit appearance including dp=1
  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // TX monitor state
  logic       in_frame = 1'b0;
  logic [7:0] cur      = 8'h00;
  int         fstart   = 0;

  // Scratch for the compare process
  int         m_dig;
  int         m_idx;
  logic [3:0] m_an;
  logic [3:0] m_nib;
  logic       m_bit;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
    if (rst) begin
      n_since_rst <= 0;
      armed       <= 1'b1;
    end else begin
      n_since_rst <= n_since_rst + 1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (armed) begin
      if (rst_seen) begin
        chk("rst_tx",  uart_tx, 1);
        chk("rst_an",  an,      4'b1110);
        chk("rst_seg", seg,     8'hC0);
        chk("rst_led", led,     0);
        chk("rst_err", err,     0);
        in_frame = 1'b0;
        exp_q.delete();
      end else if (!rst) begin
        // Each digit is driven RCNT cycles; outputs are registered one cycle late.
        m_dig = ((n_since_rst - 1) / RCNT) % ND;
        m_an  = ~(4'b0001 << m_dig);
        chk("an", an, m_an);
        if (cyc >= mask_until) begin
          m_nib = disp_m[m_dig*4 +: 4];
          chk("seg", seg, seg_tbl[m_nib]);
          chk("led", led, led_m);
          chk("err", err, err_m);
        end
        if (!in_frame) begin
          if (uart_tx === 1'b0) begin
            starts.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL tx_unexpected_start got=frame expected=idle cycle=%0d", cyc);
              cur = 8'h00;
            end else begin
              cur = exp_q.pop_front();
            end
            in_frame = 1'b1;
            fstart   = cyc;
          end else begin
            chk("tx_idle", uart_tx, 1);
          end
        end else begin
          m_idx = (cyc - fstart) / CPB;
          if (m_idx == 0)      m_bit = 1'b0;
          else if (m_idx <= 8) m_bit = cur[m_idx-1];
          else                 m_bit = 1'b1;
          chk("tx_bit", uart_tx, m_bit);
          if (cyc - fstart == 10*CPB - 1) in_frame = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame; the model learns the byte as the stop bit starts.
  task automatic send(input logic [7:0] b, input logic stop_ok);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx    = stop_ok;
    mask_until = cyc + CPB + 3;
    if (stop_ok) begin
      led_m  = ~led_m;
      disp_m = {disp_m[7:0], b};
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else                      err_m = 1'b1;
    end else begin
      err_m = 1'b1;
    end
    tick(CPB);
    uart_rx = 1'b1;
  endtask

  task automatic seg_on(input logic [3:0] an_exp, input logic [7:0] seg_exp, input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (an !== an_exp && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_an"}, an, an_exp);
    chk(nm, seg, seg_exp);
  endtask

  int t0;

  initial begin
    // 1: reset
    tick(3);
    rst   = 1'b0;
    tx_en = 1'b1;
    tick(5);

    // 2: single byte echo; start-edge to TX fall = 3 (sync+edge) + 9 (half bit)
    //    + 144 (8 data + stop sample) + 3 (push, pop, start) = 159 cycles
    t0 = cyc;
    send(8'h41, 1'b1);
    tick(170);
    chk("echo41_started", starts.size(), 1);
    if (starts.size() > 0) chk("echo41_latency", starts[0] - t0, 159);
    chk("led_after_41", led, 1);
    chk("err_after_41", err, 0);
    seg_on(4'b1110, 8'hF9, "dig0_41");
    seg_on(4'b1101, 8'h99, "dig1_41");
    seg_on(4'b1011, 8'hC0, "dig2_41");
    seg_on(4'b0111, 8'hC0, "dig3_41");

    // 3: glitch on rx
    uart_rx = 1'b0;
    tick(4);
    uart_rx = 1'b1;
    tick(40);
    chk("glitch_led", led, 1);
    chk("glitch_err", err, 0);
    chk("glitch_noecho", starts.size(), 1);

    // 4: framing error
    send(8'h55, 1'b0);
    tick(200);
    chk("frame_err", err, 1);
    chk("frame_led", led, 1);
    chk("frame_noecho", starts.size(), 1);

    // 5: fill FIFO with TX gated, fifth byte overflows
    tx_en = 1'b0;
    for (int b = 1; b <= 5; b++) send(8'(b), 1'b1);
    tick(20);
    chk("ovf_led", led, 0);
    chk("ovf_err", err, 1);
    chk("ovf_noecho", starts.size(), 1);
    tx_en = 1'b1;
    tick(4*10*CPB + 20);
    chk("burst_count", starts.size(), 5);
    if (starts.size() == 5) begin
      for (int i = 1; i < 4; i++) chk("burst_gap", starts[i+1] - starts[i], 10*CPB);
    end
    chk("burst_drained", exp_q.size(), 0);

    // 6: reset during TX data bit 3, then a fresh echo
    send(8'h3C, 1'b1);
    tick(70);
    rst    = 1'b1;
    led_m  = 1'b0;
    err_m  = 1'b0;
    disp_m = 16'h0000;
    exp_q.delete();
    tick(2);
    rst = 1'b0;
    tick(200);
    chk("post_rst_tx", uart_tx, 1);
    chk("post_rst_noecho", starts.size(), 6);
    send(8'hA5, 1'b1);
    tick(170);
    chk("a5_echo", starts.size(), 7);
    chk("a5_drained", exp_q.size(), 0);
    chk("a5_led", led, 1);
    chk("a5_err", err, 0);
    seg_on(4'b1110, 8'h92, "dig0_a5");
    seg_on(4'b1101, 8'h88, "dig1_a5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
